encoder_4x2_seq: RTL
====================

Name: encoder_4x2_seq

Overview:
- Sequential inverse of the 2-to-4 decoder: captures a request vector in which each bit maps to one decoder output line, then emits the 2-bit code of every asserted bit, one beat at a time.
- Code bit order matches the decoder select inputs: code[1]=a, code[0]=b, and bit index i = 2a+b, so code 0 selects line z[0].
- Sits on the control path ahead of the decoder and feeds it codes through a valid/ready handshake.

Parameters:
- N_IN, 4, width of the request vector; power of two, minimum 2.
- CODE_W, 2, code width; must equal log2(N_IN).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  enable; gates acceptance of new vectors only
- in_valid  input  1  request vector valid
- in_ready  output  1  block can accept a vector
- in_vec  input  N_IN  request vector; bit i requests code i
- out_valid  output  1  out_code is valid
- out_ready  input  1  consumer accepts the beat
- out_code  output  CODE_W  encoded index
- out_last  output  1  final beat of the current vector
- out_none  output  1  captured vector was all zero; out_code is don't-care (driven 0)

Behaviour:
- All outputs are registered.
- Reset (rst high at a clk edge):
  - state=IDLE, pending=0
  - out_valid=0, out_code=0, out_last=0, out_none=0
  - in_ready=0 during the reset cycle
- States: IDLE, EMIT, EMPTY.
- IDLE:
  - in_ready = en.
  - A handshake occurs when in_valid && in_ready.
  - Nonzero vector: pending <= in_vec, go to EMIT.
  - Zero vector: go to EMPTY.
  - First out_valid appears the cycle after capture (latency 1).
- EMIT:
  - out_valid=1; out_code = index of the lowest set bit of pending (fixed priority, bit 0 highest); out_last=1 when pending has exactly one bit set.
  - Beat stays stable while out_ready=0.
  - On out_valid && out_ready, that bit is cleared from pending. If out_last, go to IDLE; otherwise present the next index in the following cycle.
  - Beats are back-to-back under continuous out_ready, so a vector with k set bits takes k cycles.
- EMPTY:
  - Single beat: out_valid=1, out_none=1, out_last=1, out_code=0.
  - Go to IDLE on out_ready.
- Throughput:
  - in_ready is 0 outside IDLE, and in_ready never depends combinationally on out_ready.
  - After the last-beat handshake at cycle M, the earliest next capture is at M+1 and its first beat appears at M+2.
- en:
  - en=0 blocks capture in IDLE.
  - en has no effect in EMIT or EMPTY; an in-flight vector always drains completely.
- Reset mid-operation: pending is discarded, out_valid drops in the next cycle, no partial completion.
- in_vec is sampled only at the handshake; later changes to it are ignored.

Optional Feature:
- Macro ENCODER_PARITY_EN.
- Defined:
  - Adds output out_par (1 bit, registered, reset 0).
  - out_par = XOR of out_code bits, valid whenever out_valid=1; 0 for out_none beats.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared include file encoder_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_EMIT=2'd1, ST_EMPTY=2'd2
  - default N_IN / CODE_W constants
- Sub-module prio_enc_4x2 (combinational):
  - in: N_IN-bit vector
  - out: lowest-set index, any-set flag, one-hot flag (exactly one set)
- Top level holds the FSM, pending register and output registers.

Test Plan:
- Reset, then en=1, in_vec=4'b1011, out_ready=1 -> three consecutive beats with codes 0,1,3; out_last=1 only on code 3; in_ready returns to 1 the cycle after.
- in_vec=4'b0000 -> one beat: out_none=1, out_last=1, out_code=0; back to IDLE.
- in_vec=4'b0110; out_ready low 3 cycles, then high -> code 1 held stable for all stalled cycles, then code 2 with out_last=1.
- en=0 with in_valid=1 -> in_ready=0, no capture. Then raise en -> capture; drop en mid-EMIT -> all beats still drain.
- rst asserted during the second beat of 4'b1111 -> out_valid=0 next cycle; in_ready=0 during reset and =1 once rst is released; no stale beats follow.
- With ENCODER_PARITY_EN, in_vec=4'b1010 -> beats code 1 with out_par=1, then code 3 with out_par=0.

Source files
------------

// File: rtl/encoder_4x2_seq_pkg.sv
// Shared definitions for the sequential encoder: state encodings and default sizes.
// Imported by the encoder top and its priority-encoder helper.
package encoder_4x2_seq_pkg;

    localparam int N_IN_DEF   = 4;
    localparam int CODE_W_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_EMPTY = 2'd2
    } state_t;

endpackage

// File: rtl/encoder_4x2_seq_prio.sv
// Purpose: lowest-set-bit priority encoder (bit 0 wins) with any-set and exactly-one-set flags.
// Latency: purely combinational.
// Backpressure: none, no state.
module prio_enc_4x2
    import encoder_4x2_seq_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [N_IN-1:0]   vec,
    output logic [CODE_W-1:0] idx,
    output logic              any_set,
    output logic              one_hot
);

    always_comb begin
        idx = '0;
        // Walk from the top so the lowest set bit is the last one written.
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
        any_set = |vec;
        one_hot = any_set && ((vec & (vec - N_IN'(1))) == '0);
    end

endmodule

// File: rtl/encoder_4x2_seq.sv
// Purpose: captures a request vector and emits the code of each set bit, lowest first (ENCODER_PARITY_EN adds out_par).
// Latency: first beat one cycle after capture; k set bits drain in k back-to-back beats.
// Backpressure: beats hold stable while out_ready=0; in_ready only high in IDLE, never from out_ready.
module encoder_4x2_seq
    import encoder_4x2_seq_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic              out_none
`ifdef ENCODER_PARITY_EN
    ,
    output logic              out_par
`endif
);

    state_t              state, state_nxt;
    logic [N_IN-1:0]     pending, pending_nxt;
    logic [N_IN-1:0]     pending_clr;
    logic [N_IN-1:0]     enc_src;
    logic [CODE_W-1:0]   enc_idx;
    logic                enc_any;
    logic                enc_one_hot;
    logic                valid_nxt, last_nxt, none_nxt;
    logic [CODE_W-1:0]   code_nxt;

    // The current beat's bit, already removed, so the encoder looks ahead to the next beat.
    assign pending_clr = pending & ~(N_IN'(1) << out_code);
    assign enc_src     = (state == ST_IDLE) ? in_vec : pending_clr;
    assign in_ready    = (state == ST_IDLE) && en && !rst;

    prio_enc_4x2 #(.N_IN(N_IN), .CODE_W(CODE_W)) u_prio (
        .vec     (enc_src),
        .idx     (enc_idx),
        .any_set (enc_any),
        .one_hot (enc_one_hot)
    );

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        valid_nxt   = out_valid;
        code_nxt    = out_code;
        last_nxt    = out_last;
        none_nxt    = out_none;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    valid_nxt = 1'b1;
                    if (enc_any) begin
                        state_nxt   = ST_EMIT;
                        pending_nxt = in_vec;
                        code_nxt    = enc_idx;
                        last_nxt    = enc_one_hot;
                        none_nxt    = 1'b0;
                    end else begin
                        state_nxt = ST_EMPTY;
                        code_nxt  = '0;
                        last_nxt  = 1'b1;
                        none_nxt  = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    pending_nxt = pending_clr;
                    if (out_last) begin
                        state_nxt = ST_IDLE;
                        valid_nxt = 1'b0;
                        code_nxt  = '0;
                        last_nxt  = 1'b0;
                    end else begin
                        code_nxt = enc_idx;
                        last_nxt = enc_one_hot;
                    end
                end
            end
            ST_EMPTY: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    none_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                pending_nxt = '0;
                valid_nxt   = 1'b0;
                code_nxt    = '0;
                last_nxt    = 1'b0;
                none_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_last  <= 1'b0;
            out_none  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            out_valid <= valid_nxt;
            out_code  <= code_nxt;
            out_last  <= last_nxt;
            out_none  <= none_nxt;
        end
    end

`ifdef ENCODER_PARITY_EN
    // Code is forced to 0 when idle or on empty beats, so its XOR is 0 there too.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_par <= 1'b0;
        end else begin
            out_par <= ^code_nxt;
        end
    end
`endif

endmodule
